// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting N_REQ requesters one JK operation at a time on a
// shared WIDTH-bit JK flip-flop bank. Each accepted operation takes two cycles.
module jk_bank_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] j_in,
  input  logic [N_REQ*WIDTH-1:0] k_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic StIdle  = 1'b0;
  localparam logic StApply = 1'b1;

  logic             state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] cmd_j_q, cmd_j_d;
  logic [WIDTH-1:0] cmd_k_q, cmd_k_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             found;
  logic [PtrW-1:0]  win;
  logic [PtrW-1:0]  idx;

  // Rotating priority search; index arithmetic wraps because N_REQ is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      idx = ptr_q + PtrW'(o);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_j_d = cmd_j_q;
    cmd_k_d = cmd_k_q;
    q_d     = q_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (found) begin
          gnt_d   = N_REQ'(1) << win;
          cmd_j_d = j_in[int'(win)*WIDTH +: WIDTH];
          cmd_k_d = k_in[int'(win)*WIDTH +: WIDTH];
          ptr_d   = win + PtrW'(1);
          busy_d  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: begin
        // Characteristic JK equation: 00 hold, 01 clear, 10 set, 11 toggle.
        q_d     = (cmd_j_q & ~q_q) | (~cmd_k_q & q_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cmd_j_q <= '0;
      cmd_k_q <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_j_q <= cmd_j_d;
      cmd_k_q <= cmd_k_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: reset, JK ops, round-robin order, wrap,
// reset abort and input capture.
module tb_jk_bank_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] j_in;
  logic [N_REQ*WIDTH-1:0] k_in;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   busy;
  logic                   done;

  int n_checks = 0;
  int n_pass   = 0;

  jk_bank_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .j_in(j_in),
    .k_in(k_in),
    .gnt (gnt),
    .q   (q),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [WIDTH-1:0] j, input logic [WIDTH-1:0] k);
    j_in[i*WIDTH +: WIDTH] = j;
    k_in[i*WIDTH +: WIDTH] = k;
  endtask

  // One request pulse, then the apply cycle.
  task automatic do_op(input string tag, input logic [N_REQ-1:0] r,
                       input logic [N_REQ-1:0] exp_gnt, input logic [WIDTH-1:0] exp_q);
    req = r;
    step();
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    step();
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_gnt0"}, 32'(gnt), 32'd0);
  endtask

  logic [N_REQ-1:0] exp_g;

  initial begin
    rst  = 1'b0;
    req  = '0;
    j_in = '0;
    k_in = '0;
    step();
    step();
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Set all bits via requester 0.
    rst = 1'b1;
    set_slice(0, 8'hFF, 8'h00);
    req = 4'b0001;
    step();
    check("set_gnt", 32'(gnt), 32'h1);
    check("set_busy", 32'(busy), 32'd1);
    check("set_q_before", 32'(q), 32'h00);
    req = '0;
    step();
    check("set_q", 32'(q), 32'hFF);
    check("set_done", 32'(done), 32'd1);
    check("set_gnt0", 32'(gnt), 32'd0);
    step();
    check("set_done_once", 32'(done), 32'd0);
    check("set_q_hold", 32'(q), 32'hFF);

    // Requester 2: clear to A5, toggle twice, then a no-op.
    set_slice(2, 8'h00, 8'h5A);
    do_op("clr", 4'b0100, 4'b0100, 8'hA5);
    set_slice(2, 8'hFF, 8'hFF);
    do_op("tog1", 4'b0100, 4'b0100, 8'h5A);
    do_op("tog2", 4'b0100, 4'b0100, 8'hA5);
    set_slice(2, 8'h00, 8'h00);
    do_op("hold", 4'b0100, 4'b0100, 8'hA5);

    // ptr is now 3: req 1001 grants 3 then wraps to 0.
    set_slice(0, 8'h00, 8'h00);
    set_slice(3, 8'h00, 8'h00);
    req = 4'b1001;
    step();
    check("wrap_g3", 32'(gnt), 32'h8);
    step();
    check("wrap_gap", 32'(gnt), 32'h0);
    step();
    check("wrap_g0", 32'(gnt), 32'h1);
    req = '0;
    step();
    check("wrap_q", 32'(q), 32'hA5);

    // ptr is 1: grant requester 1, reset during apply aborts.
    set_slice(1, 8'hFF, 8'h00);
    req = 4'b0010;
    step();
    check("abort_gnt", 32'(gnt), 32'h2);
    req = '0;
    rst = 1'b0;
    step();
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_gnt0", 32'(gnt), 32'd0);
    rst = 1'b1;
    set_slice(1, 8'h00, 8'h00);

    // Continuous req=1111 from ptr=0: order 0,1,2,3,0, one grant every 2 cycles.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      step();
      check($sformatf("rr_g%0d", n), 32'(gnt), 32'(exp_g));
      check($sformatf("rr_onehot%0d", n), 32'($countones(gnt)), 32'd1);
      step();
      check($sformatf("rr_gap%0d", n), 32'(gnt), 32'd0);
    end
    req = '0;
    check("rr_q", 32'(q), 32'h00);

    // ptr is 1; requester 0 wins, inputs changed during apply are ignored.
    set_slice(0, 8'h0F, 8'h00);
    req = 4'b0001;
    step();
    check("cap_gnt", 32'(gnt), 32'h1);
    req = '0;
    set_slice(0, 8'hF0, 8'hFF);
    step();
    check("cap_q", 32'(q), 32'h0F);
    check("cap_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
